// File: rtl/aes_sub_shift_rows.sv
// AES SubBytes + ShiftRows round stage, one 32-bit column substituted per cycle.
// Optional macro AES_SSR_DECOUPLE_EN lets a new block enter while a result still waits downstream.
module aes_sub_shift_rows (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(4*c+row) +: 8] = s[8*(4*((c+row)%4)+row) +: 8];
      end
    end
    return r;
  endfunction

  state_t         state;
  state_t         state_next;
  logic [1:0]     col;
  logic [127:0]   work;
  logic           last_q;
  logic [31:0]    work_col;
  logic [31:0]    sub_col;
  logic [127:0]   sub_state;
  logic           slot_free;
  logic           accept;
  logic           load_out;

  assign work_col = work[{col, 5'b00000} +: 32];

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_col[8*i +: 8] = sbox(work_col[8*i +: 8]);
  end

  always_comb begin
    sub_state = work;
    sub_state[{col, 5'b00000} +: 32] = sub_col;
  end

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held
`ifdef AES_SSR_DECOUPLE_EN
  assign in_ready = rst_n && (state == IDLE);
`else
  assign in_ready = rst_n && (state == IDLE) && !out_valid;
`endif

  assign busy = (state == SUB);

  always_comb begin
    slot_free  = !out_valid || out_ready;
    state_next = state;
    accept     = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = SUB;
        end
      end
      SUB: begin
        if (col == 2'd3) begin
          if (slot_free) begin
            load_out   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load_out   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // HOLD keeps the substituted (unshifted) state; ShiftRows is applied on output load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= 2'd0;
      work      <= '0;
      last_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        work   <= in_data;
        last_q <= in_last;
        col    <= 2'd0;
      end else if (state == SUB) begin
        work <= sub_state;
        col  <= col + 2'd1;
      end
      if (load_out) begin
        out_data  <= shift_rows((state == SUB) ? sub_state : work);
        out_last  <= last_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
